// File: rtl/apb_mem_slave.sv
// APB4-style memory slave: DEPTH x DATA_WIDTH word array behind a SETUP/ACCESS
// handshake, with programmable wait states, byte strobes, base-address decode
// and error reporting for misaligned or out-of-range accesses.
module apb_mem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr
);

  localparam int BW  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(BW);
  localparam int IW  = $clog2(DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    err_q, err_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

  // Address decode, evaluated on the live bus; only used during setup.
  logic [ADDR_WIDTH-1:0]   off;
  logic [ADDR_WIDTH-1:0]   word_full;
  logic [IW-1:0]           dec_idx;
  logic                    dec_err;
  logic                    commit;

  assign off       = paddr - BASE_ADDR;
  assign word_full = off >> LSB;
  assign dec_idx   = word_full[IW-1:0];
  assign dec_err   = ((off & ADDR_WIDTH'(BW - 1)) != '0) ||
                     (word_full >= ADDR_WIDTH'(DEPTH));

  // Completion is gated by psel so that a dropped select (abort) never
  // reports a finished transfer.
  assign pready  = (state_q == ACCESS) && (cnt_q == 4'd0) && psel;
  assign pslverr = err_q && pready;
  assign prdata  = prdata_q;
  assign commit  = pready && penable && write_q && !err_q;

  // Next-state logic: setup latching, wait countdown, completion and abort.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    err_d    = err_q;
    write_d  = write_q;
    prdata_d = prdata_q;
    case (state_q)
      IDLE: begin
        if (psel) begin
          state_d = ACCESS;
          idx_d   = dec_idx;
          err_d   = dec_err;
          write_d = pwrite;
          cnt_d   = 4'(WAIT_STATES);
          if (!pwrite) begin
            prdata_d = dec_err ? '0 : mem_q[dec_idx];
          end
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end
          if (penable && pready) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte-lane merge of write data into the addressed word on completion.
  always_comb begin
    mem_d = mem_q;
    if (commit) begin
      for (int b = 0; b < BW; b++) begin
        if (pstrb[b]) begin
          mem_d[idx_q][8*b +: 8] = pwdata[8*b +: 8];
        end
      end
    end
  end

  // Control and read-data registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      write_q  <= write_d;
      prdata_q <= prdata_d;
    end
  end

  // Memory array; cleared by reset so every word reads back zero afterwards.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule
